// File: rtl/register_file_nr_1w_be_ff.sv
// Flip-flop register file: one byte-masked write port, NUM_READ_PORTS registered-address
// read ports, and an in-place clear sequencer that zeroes one word per cycle.
module register_file_nr_1w_be_ff #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NUM_READ_PORTS-1:0]                      ReadEnable,
  input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]      ReadAddr,
  output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]      ReadData,
  input  logic                                           WriteEnable,
  input  logic [ADDR_WIDTH-1:0]                          WriteAddr,
  input  logic [DATA_WIDTH/8-1:0]                        WriteBe,
  input  logic [DATA_WIDTH-1:0]                          WriteData,
  input  logic                                           ClearReq,
  output logic                                           Busy,
  output logic                                           ClearDone
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t                                      r_state;
  state_t                                      w_state_next;
  logic [ADDR_WIDTH-1:0]                       r_cnt;
  logic                                        r_clear_done;
  logic [DATA_WIDTH-1:0]                       r_mem [NUM_WORDS];
  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]   r_raddr;
  logic                                        w_last;

  assign w_last = (r_state == S_CLEAR) && (r_cnt == ADDR_WIDTH'(NUM_WORDS - 1));

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (ClearReq) w_state_next = S_CLEAR;
      S_CLEAR: if (w_last)   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_clear_done <= w_last;
      if (r_state == S_IDLE) r_cnt <= '0;
      else                   r_cnt <= r_cnt + ADDR_WIDTH'(1);
    end
  end

  // NOTE: the array is reset deliberately: reset must leave every word reading 0,
  // which is why this is built from flops rather than an inferred RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (WriteEnable) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (WriteBe[b]) r_mem[WriteAddr][8*b +: 8] <= WriteData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr <= '0;
    end else begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        if (ReadEnable[p]) r_raddr[p] <= ReadAddr[p];
      end
    end
  end

  // Data comes from the registered address only, so reads track later writes and sweeps.
  always_comb begin
    ReadData = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) ReadData[p] = r_mem[r_raddr[p]];
  end

  assign Busy      = (r_state == S_CLEAR);
  assign ClearDone = r_clear_done;

endmodule

// File: tb/tb_register_file_nr_1w_be_ff.sv
// Directed bench for register_file_nr_1w_be_ff: expected values are queued as each
// stimulus step is driven and popped when the matching output is sampled.
module tb_register_file_nr_1w_be_ff;

  logic             clk;
  logic             rst_n;
  logic [1:0]       ReadEnable;
  logic [1:0][4:0]  ReadAddr;
  logic [1:0][31:0] ReadData;
  logic             WriteEnable;
  logic [4:0]       WriteAddr;
  logic [3:0]       WriteBe;
  logic [31:0]      WriteData;
  logic             ClearReq;
  logic             Busy;
  logic             ClearDone;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  register_file_nr_1w_be_ff #(
    .ADDR_WIDTH    (5),
    .DATA_WIDTH    (32),
    .NUM_READ_PORTS(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ReadEnable (ReadEnable),
    .ReadAddr   (ReadAddr),
    .ReadData   (ReadData),
    .WriteEnable(WriteEnable),
    .WriteAddr  (WriteAddr),
    .WriteBe    (WriteBe),
    .WriteData  (WriteData),
    .ClearReq   (ClearReq),
    .Busy       (Busy),
    .ClearDone  (ClearDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  // Advance one edge and settle just after it; outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [3:0] be, input logic [31:0] data);
    WriteEnable = 1'b1;
    WriteAddr   = addr;
    WriteBe     = be;
    WriteData   = data;
    tick();
    WriteEnable = 1'b0;
  endtask

  task automatic rd(input int port, input logic [4:0] addr);
    ReadEnable[port] = 1'b1;
    ReadAddr[port]   = addr;
    tick();
    ReadEnable = '0;
  endtask

  // Bounded wait for the end of a sweep that is already running at the current sample.
  task automatic wait_clear(output int busy_cycles, output bit got_done);
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (Busy) busy_cycles++;
      tick();
      if (ClearDone) got_done = 1'b1;
    end
  endtask

  initial begin
    int busy_cycles;
    bit got_done;

    rst_n       = 1'b0;
    ReadEnable  = '0;
    ReadAddr    = '0;
    WriteEnable = 1'b0;
    WriteAddr   = '0;
    WriteBe     = '0;
    WriteData   = '0;
    ClearReq    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_val("reset_busy", 32'h0);          check(32'(Busy));
    expect_val("reset_cleardone", 32'h0);     check(32'(ClearDone));
    expect_val("reset_rd0", 32'h0);           check(ReadData[0]);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset then read
    rd(0, 5'd0);
    expect_val("rd_addr0", 32'h0);            check(ReadData[0]);
    rd(1, 5'd7);
    expect_val("rd_addr7", 32'h0);            check(ReadData[1]);
    rd(0, 5'd31);
    expect_val("rd_addr31", 32'h0);           check(ReadData[0]);
    expect_val("idle_busy", 32'h0);           check(32'(Busy));
    expect_val("idle_cleardone", 32'h0);      check(32'(ClearDone));

    // Byte masking
    rd(0, 5'd3);
    wr(5'd3, 4'hF, 32'hAABBCCDD);
    expect_val("be_full", 32'hAABBCCDD);      check(ReadData[0]);
    wr(5'd3, 4'b0101, 32'h11223344);
    expect_val("be_0101", 32'hAA22CC44);      check(ReadData[0]);
    wr(5'd3, 4'b0000, 32'hFFFFFFFF);
    expect_val("be_none", 32'hAA22CC44);      check(ReadData[0]);

    // Multi-port and tracking
    ReadEnable = 2'b11;
    ReadAddr   = {5'd3, 5'd3};
    tick();
    ReadEnable = '0;
    expect_val("mp_p1_before", 32'hAA22CC44); check(ReadData[1]);
    wr(5'd3, 4'hF, 32'hDEADBEEF);
    expect_val("mp_track_p0", 32'hDEADBEEF);  check(ReadData[0]);
    expect_val("mp_track_p1", 32'hDEADBEEF);  check(ReadData[1]);
    rd(1, 5'd4);
    expect_val("mp_p1_addr4", 32'h0);         check(ReadData[1]);

    // Clear sweep with a dropped write to word 5
    for (int i = 0; i < 32; i++) wr(5'(i), 4'hF, 32'hFFFFFFFF);
    ReadEnable = 2'b11;
    ReadAddr   = {5'd5, 5'd31};
    tick();
    ReadEnable = '0;
    ClearReq   = 1'b1;
    tick();
    ClearReq   = 1'b0;
    for (int n = 0; n <= 34; n++) begin
      expect_val("sw_busy", (n <= 31) ? 32'h1 : 32'h0);               check(32'(Busy));
      expect_val("sw_cleardone", (n == 32) ? 32'h1 : 32'h0);          check(32'(ClearDone));
      expect_val("sw_word31", (n < 32) ? 32'hFFFFFFFF : 32'h0);       check(ReadData[0]);
      expect_val("sw_word5", (n < 6) ? 32'hFFFFFFFF : 32'h0);         check(ReadData[1]);
      if (n == 9) begin
        WriteEnable = 1'b1;
        WriteAddr   = 5'd5;
        WriteBe     = 4'hF;
        WriteData   = 32'hA5A5A5A5;
      end else begin
        WriteEnable = 1'b0;
      end
      tick();
    end

    // Simultaneous ClearReq + write, then a back-to-back ClearReq in the ClearDone cycle
    WriteEnable = 1'b1;
    WriteAddr   = 5'd31;
    WriteBe     = 4'hF;
    WriteData   = 32'h12345678;
    ClearReq    = 1'b1;
    tick();
    WriteEnable = 1'b0;
    ClearReq    = 1'b0;
    for (int n = 0; n <= 33; n++) begin
      expect_val("sim_busy", ((n <= 31) || (n == 33)) ? 32'h1 : 32'h0); check(32'(Busy));
      expect_val("sim_cleardone", (n == 32) ? 32'h1 : 32'h0);          check(32'(ClearDone));
      expect_val("sim_word31", (n < 32) ? 32'h12345678 : 32'h0);       check(ReadData[0]);
      if (n < 33) begin
        ClearReq = (n == 32);
        tick();
      end
    end
    ClearReq = 1'b0;
    wait_clear(busy_cycles, got_done);
    expect_val("b2b_done", 32'h1);            check(32'(got_done));
    expect_val("b2b_busy_cycles", 32'd32);    check(32'(busy_cycles));

    // Reset mid-sweep
    wr(5'd31, 4'hF, 32'h55555555);
    wr(5'd20, 4'hF, 32'h66666666);
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    repeat (9) tick();
    expect_val("rs_busy_before", 32'h1);      check(32'(Busy));
    rst_n = 1'b0;
    #1;
    expect_val("rs_busy_async", 32'h0);       check(32'(Busy));
    expect_val("rs_cleardone", 32'h0);        check(32'(ClearDone));
    expect_val("rs_rd0", 32'h0);              check(ReadData[0]);
    #1;
    rst_n = 1'b1;
    ReadEnable = 2'b11;
    ReadAddr   = {5'd20, 5'd31};
    tick();
    ReadEnable = '0;
    expect_val("rs_word31", 32'h0);           check(ReadData[0]);
    expect_val("rs_word20", 32'h0);           check(ReadData[1]);
    expect_val("rs_no_done", 32'h0);          check(32'(ClearDone));
    tick();
    expect_val("rs_no_done2", 32'h0);         check(32'(ClearDone));
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    wait_clear(busy_cycles, got_done);
    expect_val("rs_fresh_done", 32'h1);       check(32'(got_done));
    expect_val("rs_fresh_busy", 32'd32);      check(32'(busy_cycles));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
